// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the CPU-side Avalon-MM initiator.
package mips_bus_pkg;

  localparam int BUS_W = 32;
  localparam int BE_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    ERR
  } bus_state_t;

  function automatic logic is_misaligned(input logic [BUS_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mips_bus_timeout.sv
// Bus-stall counter: counts enabled cycles and flags the last permitted stall cycle.
module mips_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] count_q, count_d;

  // expired fires on the stall cycle that brings the count to TIMEOUT_CYCLES,
  // so the master aborts after exactly TIMEOUT_CYCLES waitrequest cycles.
  always_comb begin
    expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired && (TIMEOUT_CYCLES != 0)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mips_avalon_master.sv
// Avalon-MM initiator: one outstanding core load/store/fetch, with alignment
// checking and a waitrequest stall timeout that returns an error response.
module mips_avalon_master
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BUS_W-1:0]  req_addr,
  input  logic [BE_W-1:0]   req_byteenable,
  input  logic [BUS_W-1:0]  req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [BUS_W-1:0]  resp_rdata,
  output logic [BUS_W-1:0]  address,
  output logic [BE_W-1:0]   byteenable,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  input  logic [BUS_W-1:0]  readdata,
  output logic [BUS_W-1:0]  writedata
);

  bus_state_t       state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [BUS_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [BUS_W-1:0] address_q, address_d;
  logic [BE_W-1:0]  byteenable_q, byteenable_d;
  logic [BUS_W-1:0] writedata_q, writedata_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             stall_expired;

  mips_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != BUS),
    .enable ((state_q == BUS) && waitrequest),
    .expired(stall_expired)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (is_misaligned(req_addr)) begin
            state_d      = ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d      = BUS;
            address_d    = req_addr;
            byteenable_d = req_byteenable;
            writedata_d  = req_wdata;
            read_d       = !req_write;
            write_d      = req_write;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_q ? readdata : '0;
        end else if (stall_expired) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end
      end
      RESP, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign read       = read_q;
  assign write      = write_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Self-checking bench: randomized core requests against a transaction-level
// model of latency, timeout, alignment and byte-lane memory updates.
module tb_mips_avalon_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_byteenable;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] writedata;

  logic [31:0] slave_mem [256];
  logic [31:0] model_mem [256];

  int errors = 0;
  int checks = 0;

  mips_avalon_master #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_byteenable(req_byteenable),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .address       (address),
    .byteenable    (byteenable),
    .read          (read),
    .write         (write),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .writedata     (writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] data);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // One complete request from the idle negedge until req_ready returns.
  // waits = number of waitrequest cycles the slave inserts before completing.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int waits);
    logic        mis, tmo;
    int          bus_cycles;
    logic [31:0] exp_rdata;
    logic [7:0]  idx;
    mis        = (addr[1:0] != 2'b00);
    tmo        = !mis && (waits >= TMO);
    bus_cycles = mis ? 0 : (tmo ? TMO : waits + 1);
    idx        = addr[9:2];
    exp_rdata  = (mis || tmo || wr) ? 32'h0 : model_mem[idx];

    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_byteenable = be; req_wdata = wd;
    @(negedge clk);
    for (int c = 0; c < bus_cycles; c++) begin
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
      req_byteenable = 4'($urandom); req_wdata = $urandom;
      check("bus_read", read, 32'(!wr));
      check("bus_write", write, 32'(wr));
      check("bus_addr", address, addr);
      check("bus_be", byteenable, 32'(be));
      if (wr) check("bus_wdata", writedata, wd);
      check("bus_not_ready", req_ready, 0);
      check("bus_no_resp", resp_valid, 0);
      if (c < waits) begin
        waitrequest = 1'b1;
        readdata    = $urandom;
      end else begin
        waitrequest = 1'b0;
        readdata    = slave_mem[address[9:2]];
        if (write) slave_mem[address[9:2]] = merge(slave_mem[address[9:2]], byteenable, writedata);
      end
      @(negedge clk);
    end
    waitrequest = 1'b0;
    check("resp_valid", resp_valid, 1);
    check("resp_err", resp_err, 32'(mis || tmo));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_read_low", read, 0);
    check("resp_write_low", write, 0);
    check("resp_not_ready", req_ready, 0);
    if (wr && !mis && !tmo) model_mem[idx] = merge(model_mem[idx], be, wd);
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_one_cycle", resp_valid, 0);
    check("ready_again", req_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic        wr;
    int          waits;

    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = $urandom;
      model_mem[i] = slave_mem[i];
    end
    slave_mem[4] = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_byteenable = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_address", address, 0);
    check("rst_rdata", resp_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0);           // zero-wait read
    run_txn(1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 3); // write, 3 stalls
    run_txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 0);           // read back lanes
    run_txn(1'b0, 32'h0000_0002, 4'hF, 32'h0, 0);           // misaligned
    run_txn(1'b0, 32'h0000_0030, 4'hF, 32'h0, TMO);         // timeout
    run_txn(1'b0, 32'h0000_0034, 4'hF, 32'h0, TMO - 1);     // just under timeout

    // Reset during a stalled read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80; req_byteenable = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; waitrequest = 1'b1;
    check("mid_read_high", read, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_read", read, 0);
    check("mid_rst_resp", resp_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    reset = 1'b1; waitrequest = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", req_ready, 1);
    check("mid_rel_resp", resp_valid, 0);

    // Back-to-back reads with req_valid held high.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_byteenable = 4'hF;
    @(negedge clk);
    check("b2b_first_read", read, 1);
    check("b2b_first_addr", address, 32'h40);
    req_addr = 32'h44;
    readdata = slave_mem[address[9:2]];
    @(negedge clk);
    check("b2b_first_resp", resp_valid, 1);
    check("b2b_first_rdata", resp_rdata, model_mem[8'h10]);
    check("b2b_no_overlap", read, 0);
    check("b2b_busy", req_ready, 0);
    @(negedge clk);
    check("b2b_ready_n3", req_ready, 1);
    check("b2b_idle_read", read, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_read", read, 1);
    check("b2b_second_addr", address, 32'h44);
    check("b2b_second_busy", req_ready, 0);
    readdata = slave_mem[address[9:2]];
    @(negedge clk);
    check("b2b_second_resp", resp_valid, 1);
    check("b2b_second_rdata", resp_rdata, model_mem[8'h11]);
    @(negedge clk);
    check("b2b_ready_end", req_ready, 1);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      waits = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 2);
      run_txn(wr, a, 4'($urandom), $urandom, waits);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
